// File: rtl/out_iface_pkg.sv
// Shared types and constants for the CPU result read-out interface.
package out_iface_pkg;

   // Frame sequencing states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } oi_state_t;

   // Bit positions of the flags inside the status nibble {1'b0, Z, N, V}.
   localparam int OI_Z_BIT = 2;
   localparam int OI_N_BIT = 1;
   localparam int OI_V_BIT = 0;

   // Builds the status nibble sent as the final nibble of every frame.
   function automatic logic [3:0] oi_status_nib(input logic z, input logic n, input logic v);
      logic [3:0] s;
      s           = 4'h0;
      s[OI_Z_BIT] = z;
      s[OI_N_BIT] = n;
      s[OI_V_BIT] = v;
      return s;
   endfunction

endpackage

// File: rtl/nib_shreg.sv
// Shadow register: parallel load of {word, status}, shift left by one nibble,
// top nibble always visible.
module nib_shreg #(
   parameter int W = 16
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           load,
   input  logic           shift,
   input  logic [W+3:0]   d,
   output logic [3:0]     top
);

   logic [W+3:0] q;

   // Load wins over shift; the two never coincide in normal operation.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end else if (shift) begin
         q <= {q[W-1:0], 4'h0};
      end
   end

   assign top = q[W+3:W];

endmodule

// File: rtl/out_iface.sv
// Output-side interface of the lab CPU board. On start it captures the
// result word and Z/N/V flags, then streams them MSB nibble first, followed
// by the status nibble, over a valid/ready handshake.
//
// Handshake: a nibble transfers on a rising edge where tx_valid and tx_ready
// are both 1. Once tx_valid rises, tx_valid, tx_data and tx_last stay
// constant until that transfer; tx_ready is ignored while tx_valid is 0.
// Every output is decoded from registers only, so no output depends on
// tx_ready or start within the same cycle.
module out_iface
   import out_iface_pkg::*;
#(
   parameter int W = 16
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   input  logic [W-1:0]  out,
   input  logic          Z,
   input  logic          N,
   input  logic          V,
   output logic          tx_valid,
   input  logic          tx_ready,
   output logic [3:0]    tx_data,
   output logic          tx_last,
   output logic          busy,
   output logic          done,
   output logic [1:0]    dbg_state
);

   localparam int NIB = W / 4;
   localparam int IW  = $clog2(NIB + 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(NIB);

   oi_state_t     state;
   oi_state_t     state_nxt;
   logic [IW-1:0] idx;
   logic [3:0]    top_nib;
   logic          load;
   logic          xfer;
   logic          shift;

   // In SEND tx_valid is always 1, so a transfer is simply SEND with ready.
   assign load  = (state == IDLE) && start;
   assign xfer  = (state == SEND) && tx_ready;
   assign shift = xfer && (idx != LAST_IDX);

   nib_shreg #(.W(W)) u_shreg (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (load),
      .shift   (shift),
      .d       ({out, oi_status_nib(Z, N, V)}),
      .top     (top_nib)
   );

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; start is only looked at in IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SEND;
         SEND:    if (xfer && (idx == LAST_IDX)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Nibble index: cleared on capture, advances with each non-final transfer,
   // so it stops at NIB and never wraps.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idx <= '0;
      end else if (load) begin
         idx <= '0;
      end else if (shift) begin
         idx <= idx + IW'(1);
      end
   end

   // Output decode from the registered state, index and shadow register.
   always_comb begin
      tx_valid = 1'b0;
      tx_data  = 4'h0;
      tx_last  = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         SEND: begin
            tx_valid = 1'b1;
            tx_data  = top_nib;
            tx_last  = (idx == LAST_IDX);
            busy     = 1'b1;
         end
         DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: begin
            tx_valid = 1'b0;
         end
      endcase
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_out_iface.sv
// Bench for out_iface: a W=16 and a W=8 instance, a queue-based frame model
// compared every cycle, and directed scenarios with literal nibble sequences.
module tb_out_iface;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   // W=16 instance signals
   logic        start16 = 1'b0, tx_ready16 = 1'b0;
   logic        z16 = 1'b0, n16 = 1'b0, v16 = 1'b0;
   logic [15:0] out16 = '0;
   logic        tx_valid16, tx_last16, busy16, done16;
   logic [3:0]  tx_data16;
   logic [1:0]  st16;

   // W=8 instance signals
   logic        start8 = 1'b0, tx_ready8 = 1'b0;
   logic        z8 = 1'b0, n8 = 1'b0, v8 = 1'b0;
   logic [7:0]  out8 = '0;
   logic        tx_valid8, tx_last8, busy8, done8;
   logic [3:0]  tx_data8;
   logic [1:0]  st8;

   int checks = 0;
   int failures = 0;

   // Model: nibbles still owed to the consumer, plus a one-cycle done flag.
   logic [3:0] exp16_q[$];
   logic [3:0] exp8_q[$];
   bit         mdone16 = 1'b0;
   bit         mdone8 = 1'b0;
   // Nibbles actually accepted from the DUTs.
   logic [3:0] obs16[$];
   logic [3:0] obs8[$];

   out_iface #(.W(16)) dut16 (
      .clk(clk), .reset_n(reset_n), .start(start16), .out(out16),
      .Z(z16), .N(n16), .V(v16), .tx_valid(tx_valid16), .tx_ready(tx_ready16),
      .tx_data(tx_data16), .tx_last(tx_last16), .busy(busy16), .done(done16),
      .dbg_state(st16)
   );

   out_iface #(.W(8)) dut8 (
      .clk(clk), .reset_n(reset_n), .start(start8), .out(out8),
      .Z(z8), .N(n8), .V(v8), .tx_valid(tx_valid8), .tx_ready(tx_ready8),
      .tx_data(tx_data8), .tx_last(tx_last8), .busy(busy8), .done(done8),
      .dbg_state(st8)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model for W=16: a frame is owed after an accepted start; done follows
   // the last accepted nibble for one cycle, during which start is ignored.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         exp16_q.delete();
         mdone16 = 1'b0;
      end else if (exp16_q.size() > 0) begin
         mdone16 = 1'b0;
         if (tx_ready16) begin
            void'(exp16_q.pop_front());
            if (exp16_q.size() == 0) mdone16 = 1'b1;
         end
      end else if (mdone16) begin
         mdone16 = 1'b0;
      end else if (start16) begin
         for (int i = 3; i >= 0; i--) exp16_q.push_back(out16[i*4 +: 4]);
         exp16_q.push_back({1'b0, z16, n16, v16});
      end
   end

   // Model for W=8.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         exp8_q.delete();
         mdone8 = 1'b0;
      end else if (exp8_q.size() > 0) begin
         mdone8 = 1'b0;
         if (tx_ready8) begin
            void'(exp8_q.pop_front());
            if (exp8_q.size() == 0) mdone8 = 1'b1;
         end
      end else if (mdone8) begin
         mdone8 = 1'b0;
      end else if (start8) begin
         for (int i = 1; i >= 0; i--) exp8_q.push_back(out8[i*4 +: 4]);
         exp8_q.push_back({1'b0, z8, n8, v8});
      end
   end

   // Transfer log
   always @(posedge clk) begin
      if (reset_n && tx_valid16 && tx_ready16) obs16.push_back(tx_data16);
      if (reset_n && tx_valid8 && tx_ready8) obs8.push_back(tx_data8);
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      logic [3:0] ed;
      logic       ev;
      ev = (exp16_q.size() > 0);
      ed = 4'h0;
      if (ev) ed = exp16_q[0];
      check("tx_valid16", tx_valid16, ev);
      check("tx_data16", tx_data16, ed);
      check("tx_last16", tx_last16, ev && (exp16_q.size() == 1));
      check("busy16", busy16, ev || mdone16);
      check("done16", done16, mdone16);
      ev = (exp8_q.size() > 0);
      ed = 4'h0;
      if (ev) ed = exp8_q[0];
      check("tx_valid8", tx_valid8, ev);
      check("tx_data8", tx_data8, ed);
      check("tx_last8", tx_last8, ev && (exp8_q.size() == 1));
      check("busy8", busy8, ev || mdone8);
      check("done8", done8, mdone8);
   end

   // Pulse start for one cycle and count cycles until done is seen.
   task automatic run_frame16(output int n);
      @(negedge clk);
      start16 = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         start16 = 1'b0;
      end while (!done16 && n < 60);
      check("frame16_done_reached", done16, 1'b1);
   endtask

   task automatic run_frame8(output int n);
      @(negedge clk);
      start8 = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         start8 = 1'b0;
      end while (!done8 && n < 60);
      check("frame8_done_reached", done8, 1'b1);
   endtask

   // Compare the accepted nibbles with a literal sequence, MS nibble first.
   task automatic check_log16(input string name, input logic [39:0] seq, input int n);
      check({name, "_len"}, obs16.size(), n);
      for (int i = 0; i < n; i++) begin
         if (i < obs16.size()) check(name, obs16[i], seq[(n-1-i)*4 +: 4]);
      end
      obs16.delete();
   endtask

   task automatic check_log8(input string name, input logic [39:0] seq, input int n);
      check({name, "_len"}, obs8.size(), n);
      for (int i = 0; i < n; i++) begin
         if (i < obs8.size()) check(name, obs8[i], seq[(n-1-i)*4 +: 4]);
      end
      obs8.delete();
   endtask

   task automatic check_zero16(input string name);
      check({name, "_valid"}, tx_valid16, 1'b0);
      check({name, "_data"}, tx_data16, 4'h0);
      check({name, "_last"}, tx_last16, 1'b0);
      check({name, "_busy"}, busy16, 1'b0);
      check({name, "_done"}, done16, 1'b0);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   initial begin
      int n;

      // Reset state
      repeat (3) @(negedge clk);
      check_zero16("reset");
      check("reset_valid8", tx_valid8, 1'b0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // Basic frame: A,5,C,3 then status {0,Z=0,N=1,V=0} = 2
      out16 = 16'hA5C3; z16 = 1'b0; n16 = 1'b1; v16 = 1'b0;
      tx_ready16 = 1'b1;
      run_frame16(n);
      check("basic_done_cycle", n, 6);
      repeat (2) @(negedge clk);
      check("basic_busy_after", busy16, 1'b0);
      check_log16("basic_seq", 40'hA5C32, 5);

      // Backpressure: ready low 3 cycles before each nibble; status = 5
      out16 = 16'h1234; z16 = 1'b1; n16 = 1'b0; v16 = 1'b1;
      @(negedge clk);
      start16 = 1'b1;
      tx_ready16 = 1'b0;
      for (int k = 0; k < 5; k++) begin
         repeat (3) begin
            @(negedge clk);
            start16 = 1'b0;
            tx_ready16 = 1'b0;
         end
         @(negedge clk);
         tx_ready16 = 1'b1;
      end
      @(negedge clk);
      tx_ready16 = 1'b0;
      repeat (4) @(negedge clk);
      check("bp_busy_after", busy16, 1'b0);
      check_log16("bp_seq", 40'h12345, 5);

      // Start while busy and capture isolation: status {0,1,1,0} = 6
      tx_ready16 = 1'b1;
      out16 = 16'h3C96; z16 = 1'b1; n16 = 1'b1; v16 = 1'b0;
      @(negedge clk);
      start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      out16 = 16'hFFFF; z16 = 1'b0; n16 = 1'b0; v16 = 1'b1;
      @(negedge clk);
      start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      repeat (2) @(negedge clk);
      @(negedge clk);
      check("dup_in_done", done16, 1'b1);
      start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      repeat (10) @(negedge clk);
      check("dup_busy_after", busy16, 1'b0);
      check_log16("isolation_seq", 40'h3C966, 5);

      // Back-to-back: start in the first IDLE cycle after done
      run_frame16(n);
      @(negedge clk);
      start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      repeat (10) @(negedge clk);
      check_log16("b2b_seq", 40'hFFFF1FFFF1, 10);

      // Reset mid-frame after the second nibble is accepted
      out16 = 16'hA5C3; z16 = 1'b0; n16 = 1'b1; v16 = 1'b0;
      @(negedge clk);
      start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      repeat (2) @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check_zero16("async_rst");
      check_log16("rst_partial", 40'hA5, 2);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      check_zero16("after_rst_idle");
      out16 = 16'h0BAD; z16 = 1'b0; n16 = 1'b0; v16 = 1'b1;
      run_frame16(n);
      check("post_rst_done_cycle", n, 6);
      repeat (2) @(negedge clk);
      check_log16("post_rst_seq", 40'h0BAD1, 5);

      // W=8: 7, E, status {0,0,1,0} = 2
      out8 = 8'h7E; z8 = 1'b0; n8 = 1'b1; v8 = 1'b0;
      tx_ready8 = 1'b1;
      run_frame8(n);
      check("w8_done_cycle", n, 4);
      repeat (3) @(negedge clk);
      check("w8_busy_after", busy8, 1'b0);
      check_log8("w8_seq", 40'h7E2, 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/out_iface.md
# out_iface

Output-side interface of the lab CPU board: the read-out counterpart of the switch-driven input interface that writes the 16-bit instruction word a byte at a time. On a start strobe it captures the datapath result word and the Z/N/V status flags, then sends them nibble by nibble, most significant first, over a valid/ready handshake. A downstream display scanner or serial transmitter consumes the nibbles. It sits beside the CPU and reads `out`, `Z`, `N` and `V` from it.

## Interface
- One clock; reset is asynchronous and active-low.
- Parameters:
  - `W`, default 16: captured word width. Must be a multiple of 4 and at least 4. `NIB = W/4`.
- Ports:
  - `clk`, input, 1 bit: rising-edge clock.
  - `reset_n`, input, 1 bit: asynchronous active-low reset.
  - `start`, input, 1 bit: capture request, sampled on `clk`.
  - `out`, input, `W` bits: CPU result word.
  - `Z`, `N`, `V`, input, 1 bit each: CPU status flags.
  - `tx_valid`, output, 1 bit: the current nibble is valid.
  - `tx_ready`, input, 1 bit: the consumer accepts the nibble.
  - `tx_data`, output, 4 bits: the current nibble.
  - `tx_last`, output, 1 bit: marks the final nibble of the frame (the status nibble).
  - `busy`, output, 1 bit: high whenever the state is not IDLE.
  - `done`, output, 1 bit: one-cycle pulse after the frame completes.

## Operation
- A frame is `NIB+1` nibbles: `out[W-1:W-4]`, then the next nibbles down to `out[3:0]`, then the status nibble `{1'b0,Z,N,V}`.
- States and transitions:
  - IDLE -> SEND: when `start`=1. On the same edge, `{out,Z,N,V}` is latched into the shadow register and the index is cleared to 0.
  - SEND -> SEND: on each transfer (`tx_valid && tx_ready`) while index < `NIB`. The index increments by 1 and the shadow register shifts left by 4.
  - SEND -> DONE: on the transfer of index `NIB` (the status nibble).
  - DONE -> IDLE: unconditionally after one cycle.
- `start` is ignored in SEND and DONE. No queueing and no error flag.
- `out`, `Z`, `N` and `V` are not used after capture. Changes to them mid-frame do not affect the frame in progress.
- `tx_data` always equals the top nibble of the shadow register (the status nibble when index = `NIB`). It is forced to 0 outside SEND.
- The index width is `$clog2(NIB+1)`. The index never exceeds `NIB` and never wraps.

## Timing
- All outputs are registered. None of them depends combinationally on `tx_ready` or `start`.
- Reset values: `tx_valid`=0, `tx_data`=0, `tx_last`=0, `busy`=0, `done`=0, state IDLE, shadow register 0, index 0.
- Reset takes effect immediately and asynchronously, including mid-frame. After reset the partial frame is abandoned and is not resumed.
- Latency: `start` sampled at edge k gives `tx_valid`=1 with the first nibble during cycle k+1.
- Handshake rules:
  - Once `tx_valid` is raised, it stays high and `tx_data`/`tx_last` stay stable until the transfer occurs.
  - Backpressure is unbounded.
  - `tx_ready` is a don't-care while `tx_valid`=0.
- `tx_last` is 1 exactly when `tx_valid`=1 and index = `NIB`.
- With `tx_ready` held at 1, the frame occupies cycles k+1 through k+NIB+1. `done`=1 in cycle k+NIB+2, and the block is back in IDLE in cycle k+NIB+3. The earliest accepted next `start` is sampled at the end of that cycle.
- `done` is high only in DONE, while `tx_valid`=0 and `busy`=1.

## Structure
- Package `out_iface_pkg` holds:
  - the state enum `oi_state_t` {IDLE, SEND, DONE};
  - the status nibble bit positions `OI_Z_BIT`=2, `OI_N_BIT`=1, `OI_V_BIT`=0.
- One sub-module, `nib_shreg`: a parallel-load, shift-left-by-4 register of width `W+4` with a `load` input and a `shift` input. It exposes the top nibble.
- The FSM, the index counter and the output registers live in `out_iface`.

## Test plan
- Basic frame:
  - Stimulus: W=16, `tx_ready`=1, `out`=16'hA5C3, Z=0, N=1, V=0, one-cycle `start`.
  - Required response: nibbles A, 5, C, 3, 2 on consecutive cycles k+1..k+5, `tx_last` only with 2, `done` in cycle k+6, then `busy`=0.
- Backpressure:
  - Stimulus: `out`=16'h1234, Z=1, N=0, V=1, with `tx_ready` low for 3 cycles before each nibble.
  - Required response: each nibble held stable while stalled; sequence 1, 2, 3, 4, 5; exactly 5 transfers.
- Start while busy and capture isolation:
  - Stimulus: `start` pulsed again during SEND and during DONE, with `out` changed to 16'hFFFF right after capture.
  - Required response: the original frame is unchanged and no second frame is sent.
  - Stimulus: `start` in the first IDLE cycle after DONE.
  - Required response: accepted, and a new frame of F, F, F, F, status.
- Reset mid-frame:
  - Stimulus: assert `reset_n`=0 asynchronously after the second nibble.
  - Required response: all outputs 0 immediately, with no clock edge needed.
  - Stimulus: release reset, then `start` with `out`=16'h0BAD, V=1.
  - Required response: 0, B, A, D, 1 from index 0.
- Parameter width:
  - Stimulus: W=8, `out`=8'h7E, N=1.
  - Required response: nibbles 7, E, 2; `done` 4 cycles after `start`.
